// File: rtl/four_in_and_gate_b_pkg.sv
// -----------------------------------------------------------------------------
// four_and_pkg
// Shared constants and types for the registered four-input AND cell.
//   DEF_WIDTH : default data width of every operand and result
//   DEF_CNT_W : default width of the optional g-high event counter
//   data_t    : operand vector type at the default width
//   CNT_MAX   : saturation value of the counter at the default width
// -----------------------------------------------------------------------------
package four_and_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 16;

    typedef logic [DEF_WIDTH-1:0] data_t;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = {DEF_CNT_W{1'b1}};

endpackage : four_and_pkg

// File: rtl/four_in_and_gate_b_and2_cell.sv
// -----------------------------------------------------------------------------
// and2_cell
// Purely combinational bitwise 2-input AND: y = x0 & x1.
// Ports:
//   x0 : WIDTH-bit operand 0
//   x1 : WIDTH-bit operand 1
//   y  : WIDTH-bit result
// -----------------------------------------------------------------------------
module and2_cell
    import four_and_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    output logic [WIDTH-1:0] y
);

    // One gate per bit; no interaction between bit lanes.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign y[gi] = x0[gi] & x1[gi];
    end

endmodule : and2_cell

// File: rtl/four_in_and_gate_b.sv
// -----------------------------------------------------------------------------
// four_in_and_gate_b
// Registered four-input bitwise AND built from three 2-input AND stages
// (e = a&b, f = c&d, g = e&f). All three products come from the same input
// sample and are registered together, so g never mixes cycles.
//
// Optional build macro: FOUR_AND_CNT_EN adds the CNT_W parameter and the
// saturating g_count output, counting valid samples whose g is all-ones.
//
// Ports:
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   in_valid  : a, b, c, d valid this cycle
//   a, b, c, d: WIDTH-bit operands
//   out_valid : e, f, g were updated from a valid sample on the last edge
//   g_count   : CNT_W-bit saturating event counter (FOUR_AND_CNT_EN only)
//   e, f, g   : registered a&b, c&d, a&b&c&d
// -----------------------------------------------------------------------------
module four_in_and_gate_b
    import four_and_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef FOUR_AND_CNT_EN
    ,
    parameter int CNT_W = DEF_CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
`ifdef FOUR_AND_CNT_EN
    output logic [CNT_W-1:0] g_count,
`endif
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [WIDTH-1:0] g
);

    // Combinational products of the current sample.
    logic [WIDTH-1:0] e_d;
    logic [WIDTH-1:0] f_d;
    logic [WIDTH-1:0] g_d;

    logic [WIDTH-1:0] e_q;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] g_q;
    logic             valid_q;

    and2_cell #(.WIDTH(WIDTH)) u_ab (
        .x0 (a),
        .x1 (b),
        .y  (e_d)
    );

    and2_cell #(.WIDTH(WIDTH)) u_cd (
        .x0 (c),
        .x1 (d),
        .y  (f_d)
    );

    // Fed from the unregistered partials so g is built from the same sample.
    and2_cell #(.WIDTH(WIDTH)) u_ef (
        .x0 (e_d),
        .x1 (f_d),
        .y  (g_d)
    );

    // Products load only on valid samples; otherwise they hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                e_q <= e_d;
                f_q <= f_d;
                g_q <= g_d;
            end
        end
    end

    assign e         = e_q;
    assign f         = f_q;
    assign g         = g_q;
    assign out_valid = valid_q;

`ifdef FOUR_AND_CNT_EN
    localparam logic [CNT_W-1:0] CNT_TOP = {CNT_W{1'b1}};

    logic [CNT_W-1:0] g_count_q;
    logic [CNT_W-1:0] g_count_d;

    // Count valid samples with every bit of g set; stick at the top value.
    always_comb begin
        g_count_d = g_count_q;
        if (in_valid && (g_d == {WIDTH{1'b1}}) && (g_count_q != CNT_TOP)) begin
            g_count_d = g_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_count_q <= '0;
        end else begin
            g_count_q <= g_count_d;
        end
    end

    assign g_count = g_count_q;
`endif

endmodule : four_in_and_gate_b

// File: tb/tb_four_in_and_gate_b.sv
// -----------------------------------------------------------------------------
// tb_four_in_and_gate_b
// Directed self-checking bench: a WIDTH=1 instance for the truth-table sweep,
// partial products, hold and mid-operation reset; a WIDTH=4 instance for the
// bitwise vector and, with FOUR_AND_CNT_EN, the saturating counter (CNT_W=2).
// -----------------------------------------------------------------------------
module tb_four_in_and_gate_b;

    logic clk;
    logic rst_n;

    // WIDTH=1 instance
    logic v1, a1, b1, c1, d1;
    logic ov1, e1, f1, g1;

    // WIDTH=4 instance
    logic       v4;
    logic [3:0] a4, b4, c4, d4;
    logic       ov4;
    logic [3:0] e4, f4, g4;

`ifdef FOUR_AND_CNT_EN
    logic [15:0] cnt1;
    logic [1:0]  cnt4;
`endif

    int tests_run;
    int tests_failed;

    four_in_and_gate_b #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v1),
        .a         (a1),
        .b         (b1),
        .c         (c1),
        .d         (d1),
        .out_valid (ov1),
`ifdef FOUR_AND_CNT_EN
        .g_count   (cnt1),
`endif
        .e         (e1),
        .f         (f1),
        .g         (g1)
    );

    four_in_and_gate_b #(
        .WIDTH(4)
`ifdef FOUR_AND_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v4),
        .a         (a4),
        .b         (b4),
        .c         (c4),
        .d         (d4),
        .out_valid (ov4),
`ifdef FOUR_AND_CNT_EN
        .g_count   (cnt4),
`endif
        .e         (e4),
        .f         (f4),
        .g         (g4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c, input logic d);
        v1 = v; a1 = a; b1 = b; c1 = c; d1 = d;
    endtask

    task automatic check1(input string tag, input logic ov, input logic e, input logic f, input logic g);
        check_val({tag, ".ov"}, {31'd0, ov1}, {31'd0, ov});
        check_val({tag, ".e"},  {31'd0, e1},  {31'd0, e});
        check_val({tag, ".f"},  {31'd0, f1},  {31'd0, f});
        check_val({tag, ".g"},  {31'd0, g1},  {31'd0, g});
        $display("[TB] %s v=%0b abcd=%0b%0b%0b%0b -> ov=%0b e=%0b f=%0b g=%0b",
                 tag, v1, a1, b1, c1, d1, ov1, e1, f1, g1);
    endtask

    // Hand-computed sweep results, index = {a,b,c,d}.
    localparam logic [15:0] SWEEP_E = 16'hF000; // a=b=1 for indices 12..15
    localparam logic [15:0] SWEEP_F = 16'h8888; // c=d=1 for indices 3,7,11,15
    localparam logic [15:0] SWEEP_G = 16'h8000; // only index 15

    initial begin
        logic [15:0] se, sf, sg;
        logic [3:0]  idx;
        tests_run    = 0;
        tests_failed = 0;
        se = SWEEP_E; sf = SWEEP_F; sg = SWEEP_G;

        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v4 = 1'b0; a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; d4 = 4'h0;

        // Reset state before any clock edge.
        #3;
        check1("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("reset.ov4", {31'd0, ov4}, 32'd0);
        check_val("reset.g4",  {28'd0, g4},  32'd0);
`ifdef FOUR_AND_CNT_EN
        check_val("reset.cnt1", {16'd0, cnt1}, 32'd0);
        check_val("reset.cnt4", {30'd0, cnt4}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check1("post_release", 1'b0, 1'b0, 1'b0, 1'b0);

        // Exhaustive truth-table sweep, d fastest, a slowest.
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            drive1(1'b1, idx[3], idx[2], idx[1], idx[0]);
            tick();
            check1($sformatf("sweep%0d", i), 1'b1, se[i], sf[i], sg[i]);
        end

        // Partial products.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check1("partial_1110", 1'b1, 1'b1, 1'b0, 1'b0);
        drive1(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        check1("partial_0111", 1'b1, 1'b0, 1'b1, 1'b0);

        // Hold: load all-ones, then drop valid with a=0 for three cycles.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check1("hold_load", 1'b1, 1'b1, 1'b1, 1'b1);
        drive1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b1, 1'b1);
        end

        // Mid-cycle reset with outputs nonzero: must clear before any edge.
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check1("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check1("reset_held", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check1("release_idle", 1'b0, 1'b0, 1'b0, 1'b0);
        drive1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        check1("first_valid", 1'b1, 1'b1, 1'b1, 1'b1);
        drive1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bitwise, WIDTH=4.
        v4 = 1'b1; a4 = 4'hF; b4 = 4'hA; c4 = 4'hC; d4 = 4'hE;
        tick();
        check_val("bitwise.ov", {31'd0, ov4}, 32'd1);
        check_val("bitwise.e",  {28'd0, e4},  32'hA);
        check_val("bitwise.f",  {28'd0, f4},  32'hC);
        check_val("bitwise.g",  {28'd0, g4},  32'h8);
        $display("[TB] bitwise a=%h b=%h c=%h d=%h -> e=%h f=%h g=%h", a4, b4, c4, d4, e4, f4, g4);
`ifdef FOUR_AND_CNT_EN
        check_val("bitwise.cnt", {30'd0, cnt4}, 32'd0);

        // Saturating counter, CNT_W=2: 1, 2, 3, 3, 3.
        a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; d4 = 4'hF;
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp_cnt;
            exp_cnt = (i < 3) ? 2'(i + 1) : 2'd3;
            tick();
            check_val($sformatf("cnt%0d", i), {30'd0, cnt4}, {30'd0, exp_cnt});
            $display("[TB] count step %0d g=%h g_count=%0d", i, g4, cnt4);
        end
        v4 = 1'b0;
        tick();
        check_val("cnt_idle", {30'd0, cnt4}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("cnt_reset", {30'd0, cnt4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif
        v4 = 1'b0;
        tick();
        check_val("final_ov4", {31'd0, ov4}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_four_in_and_gate_b
